// File: rtl/adc_meter_pkg.sv
// rtl/adc_meter_pkg.sv - shared constants, hold FSM encoding and width helper for the ADC level meter
// Contents:
//   MAG_W         width of a saturated sample magnitude
//   hold_state_e  overload-hold FSM states
//   clog2_min1    counter width able to hold values 0..value-1, never less than 1 bit
package adc_meter_pkg;

  localparam int MAG_W = 15;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_OVL   = 1'b1
  } hold_state_e;

  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/adc_abs_sat.sv
// rtl/adc_abs_sat.sv - registered saturating magnitude of a signed 16-bit sample plus its valid bit
// Ports:
//   clk_i    in   sample clock
//   rst_i    in   synchronous active-high reset
//   data_i   in   signed two's-complement sample
//   en_i     in   sample qualifier
//   mag_o    out  registered |data_i|, -32768 saturates to 32767
//   valid_o  out  registered en_i, aligned with mag_o
module adc_abs_sat
  import adc_meter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      data_i,
  input  logic             en_i,
  output logic [MAG_W-1:0] mag_o,
  output logic             valid_o
);

  logic [MAG_W-1:0] mag_d, mag_q;
  logic             valid_q;

  always_comb begin
    mag_d = data_i[14:0];
    if (data_i[15]) begin
      // Only -32768 has no positive 16-bit counterpart; the low 15 bits of
      // the two's-complement negation are exact for every other negative value.
      if (data_i[14:0] == 15'd0) begin
        mag_d = 15'h7fff;
      end else begin
        mag_d = ~data_i[14:0] + 15'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      valid_q <= en_i;
    end
  end

  assign mag_o   = mag_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/adc_level_meter.sv
// rtl/adc_level_meter.sv - windowed peak/mean magnitude and overload meter with sticky flag and hold output
// Ports:
//   clk_i         in   sample clock
//   rst_i         in   synchronous active-high reset
//   data_in       in   signed 16-bit sample from the data latch
//   en_i          in   sample qualifier
//   thresh_i      in   overload magnitude threshold, 0 disables overload detection
//   clr_i         in   clears window, accumulators and sticky flag
//   peak_o        out  max |x| of the last completed window
//   mean_o        out  sum(|x|) >> WINDOW_LOG2 of the last completed window
//   ovf_count_o   out  overload samples in the last completed window
//   meas_valid_o  out  one-cycle pulse when results load
//   ovf_flag_o    out  sticky overload flag
//   ovf_hold_o    out  high for HOLD_CYCLES cycles after the last overload
module adc_level_meter
  import adc_meter_pkg::*;
#(
  parameter int WINDOW_LOG2 = 16,
  parameter int HOLD_CYCLES = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [15:0]            data_in,
  input  logic                   en_i,
  input  logic [MAG_W-1:0]       thresh_i,
  input  logic                   clr_i,
  output logic [MAG_W-1:0]       peak_o,
  output logic [MAG_W-1:0]       mean_o,
  output logic [WINDOW_LOG2:0]   ovf_count_o,
  output logic                   meas_valid_o,
  output logic                   ovf_flag_o,
  output logic                   ovf_hold_o
);

  localparam int SUM_W  = MAG_W + WINDOW_LOG2;
  localparam int CNT_W  = WINDOW_LOG2 + 1;
  localparam int HOLD_W = clog2_min1(HOLD_CYCLES);

  localparam logic [WINDOW_LOG2-1:0] WIN_LAST    = '1;
  localparam logic [HOLD_W-1:0]      HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  // Stage 1
  logic [MAG_W-1:0] s1_mag;
  logic             s1_valid;

  adc_abs_sat u_abs_sat (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_in),
    .en_i    (en_i),
    .mag_o   (s1_mag),
    .valid_o (s1_valid)
  );

  logic ovl;
  assign ovl = s1_valid & (thresh_i != '0) & (s1_mag >= thresh_i);

  // Stage 2 state
  logic [WINDOW_LOG2-1:0] win_cnt_d, win_cnt_q;
  logic [MAG_W-1:0]       peak_acc_d, peak_acc_q;
  logic [SUM_W-1:0]       sum_acc_d, sum_acc_q;
  logic [CNT_W-1:0]       cnt_acc_d, cnt_acc_q;

  logic [MAG_W-1:0]       peak_out_d, peak_out_q;
  logic [MAG_W-1:0]       mean_out_d, mean_out_q;
  logic [CNT_W-1:0]       cnt_out_d, cnt_out_q;
  logic                   meas_d, meas_q;
  logic                   flag_d, flag_q;

  hold_state_e            state_d, state_q;
  logic [HOLD_W-1:0]      hold_cnt_d, hold_cnt_q;

  // Window totals including the current stage-1 sample
  logic [MAG_W-1:0] peak_next;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_next;
  logic             win_close;

  assign peak_next = (s1_mag > peak_acc_q) ? s1_mag : peak_acc_q;
  assign sum_next  = sum_acc_q + SUM_W'(s1_mag);
  assign cnt_next  = cnt_acc_q + CNT_W'(ovl);
  // A clear on the closing cycle discards the window instead of publishing it.
  assign win_close = s1_valid & (win_cnt_q == WIN_LAST) & ~clr_i;

  always_comb begin
    win_cnt_d  = win_cnt_q;
    peak_acc_d = peak_acc_q;
    sum_acc_d  = sum_acc_q;
    cnt_acc_d  = cnt_acc_q;
    peak_out_d = peak_out_q;
    mean_out_d = mean_out_q;
    cnt_out_d  = cnt_out_q;
    meas_d     = win_close;
    // Set wins over clear.
    flag_d     = ovl | (flag_q & ~clr_i);

    if (clr_i) begin
      win_cnt_d  = '0;
      peak_acc_d = '0;
      sum_acc_d  = '0;
      cnt_acc_d  = '0;
    end else if (s1_valid) begin
      if (win_cnt_q == WIN_LAST) begin
        win_cnt_d  = '0;
        peak_acc_d = '0;
        sum_acc_d  = '0;
        cnt_acc_d  = '0;
        peak_out_d = peak_next;
        mean_out_d = sum_next[SUM_W-1:WINDOW_LOG2];
        cnt_out_d  = cnt_next;
      end else begin
        win_cnt_d  = win_cnt_q + WINDOW_LOG2'(1);
        peak_acc_d = peak_next;
        sum_acc_d  = sum_next;
        cnt_acc_d  = cnt_next;
      end
    end
  end

  // Hold FSM: the counter runs regardless of en_i.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      S_CLEAR: begin
        if (ovl) begin
          state_d    = S_OVL;
          hold_cnt_d = HOLD_RELOAD;
        end
      end
      S_OVL: begin
        if (ovl) begin
          hold_cnt_d = HOLD_RELOAD;
        end else if (clr_i || (hold_cnt_q == '0)) begin
          state_d    = S_CLEAR;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d    = S_CLEAR;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_cnt_q  <= '0;
      peak_acc_q <= '0;
      sum_acc_q  <= '0;
      cnt_acc_q  <= '0;
      peak_out_q <= '0;
      mean_out_q <= '0;
      cnt_out_q  <= '0;
      meas_q     <= 1'b0;
      flag_q     <= 1'b0;
      state_q    <= S_CLEAR;
      hold_cnt_q <= '0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      peak_acc_q <= peak_acc_d;
      sum_acc_q  <= sum_acc_d;
      cnt_acc_q  <= cnt_acc_d;
      peak_out_q <= peak_out_d;
      mean_out_q <= mean_out_d;
      cnt_out_q  <= cnt_out_d;
      meas_q     <= meas_d;
      flag_q     <= flag_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign peak_o       = peak_out_q;
  assign mean_o       = mean_out_q;
  assign ovf_count_o  = cnt_out_q;
  assign meas_valid_o = meas_q;
  assign ovf_flag_o   = flag_q;
  assign ovf_hold_o   = (state_q == S_OVL);

endmodule

// File: tb/tb_adc_level_meter.sv
// tb/tb_adc_level_meter.sv - scoreboard testbench for adc_level_meter
module tb_adc_level_meter;

  localparam int WL = 4;
  localparam int HC = 8;
  localparam int WN = 1 << WL;

  logic          clk_i;
  logic          rst_i;
  logic [15:0]   data_in;
  logic          en_i;
  logic [14:0]   thresh_i;
  logic          clr_i;
  logic [14:0]   peak_o;
  logic [14:0]   mean_o;
  logic [WL:0]   ovf_count_o;
  logic          meas_valid_o;
  logic          ovf_flag_o;
  logic          ovf_hold_o;

  adc_level_meter #(
    .WINDOW_LOG2 (WL),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_in      (data_in),
    .en_i         (en_i),
    .thresh_i     (thresh_i),
    .clr_i        (clr_i),
    .peak_o       (peak_o),
    .mean_o       (mean_o),
    .ovf_count_o  (ovf_count_o),
    .meas_valid_o (meas_valid_o),
    .ovf_flag_o   (ovf_flag_o),
    .ovf_hold_o   (ovf_hold_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cap = 0;
  int meas_cyc = 0;
  int meas_n = 0;
  int hold_hi_n = 0;

  typedef struct {
    int peak;
    int mean;
    int cnt;
  } res_t;
  res_t sb[$];

  // Reference model state
  int  p_abs = 0;
  bit  p_v = 1'b0;
  int  m_peak = 0, m_sum = 0, m_cnt = 0, m_n = 0;
  bit  exp_meas = 1'b0;
  bit  exp_flag = 1'b0;
  int  hold_rem = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int absat(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic drive(input logic [15:0] d, input logic e, input logic c);
    @(negedge clk_i);
    data_in  = d;
    en_i     = e;
    clr_i    = c;
    last_cap = cyc + 1;
  endtask

  // Model: advances once per rising edge from the stimulus the bench applied.
  initial begin
    bit ovl;
    res_t r;
    forever begin
      @(posedge clk_i);
      cyc++;
      if (rst_i) begin
        p_v = 1'b0; p_abs = 0;
        m_peak = 0; m_sum = 0; m_cnt = 0; m_n = 0;
        exp_meas = 1'b0; exp_flag = 1'b0; hold_rem = 0;
        sb.delete();
      end else begin
        ovl = p_v && (thresh_i != 0) && (p_abs >= int'(thresh_i));
        exp_meas = 1'b0;
        if (ovl) exp_flag = 1'b1;
        else if (clr_i) exp_flag = 1'b0;
        if (ovl) hold_rem = HC;
        else if (clr_i) hold_rem = 0;
        else if (hold_rem > 0) hold_rem--;
        if (clr_i) begin
          m_peak = 0; m_sum = 0; m_cnt = 0; m_n = 0;
        end else if (p_v) begin
          if (p_abs > m_peak) m_peak = p_abs;
          m_sum += p_abs;
          m_cnt += int'(ovl);
          m_n++;
          if (m_n == WN) begin
            r.peak = m_peak;
            r.mean = m_sum / WN;
            r.cnt  = m_cnt;
            sb.push_back(r);
            exp_meas = 1'b1;
            m_peak = 0; m_sum = 0; m_cnt = 0; m_n = 0;
          end
        end
        p_abs = absat(data_in);
        p_v   = en_i;
      end
    end
  end

  // Monitor: samples DUT outputs on the falling edge.
  initial begin
    res_t r;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      chk("meas_valid", meas_valid_o, exp_meas);
      chk("ovf_flag", ovf_flag_o, exp_flag);
      chk("ovf_hold", ovf_hold_o, hold_rem > 0);
      if (ovf_hold_o === 1'b1) hold_hi_n++;
      if (meas_valid_o === 1'b1) begin
        meas_cyc = cyc;
        meas_n++;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          r = sb.pop_front();
          chk("sb_peak", peak_o, r.peak);
          chk("sb_mean", mean_o, r.mean);
          chk("sb_cnt", ovf_count_o, r.cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first;
    int meas_before;
    rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; data_in = '0; thresh_i = '0;

    // Reset with random input activity
    repeat (3) drive(16'($urandom), 1'($urandom), 1'b0);
    @(negedge clk_i);
    chk("rst_peak", peak_o, 0);
    chk("rst_mean", mean_o, 0);
    chk("rst_cnt", ovf_count_o, 0);
    chk("rst_meas", meas_valid_o, 0);
    chk("rst_flag", ovf_flag_o, 0);
    chk("rst_hold", ovf_hold_o, 0);
    rst_i = 1'b0; en_i = 1'b0; data_in = '0;

    // Ramp 0..15, overload detection disabled, first-window latency
    thresh_i = 15'd0;
    hold_hi_n = 0;
    meas_cyc = 0;
    first = 0;
    for (int i = 0; i < WN; i++) begin
      drive(16'(i), 1'b1, 1'b0);
      if (i == 0) first = last_cap;
    end
    repeat (3) drive(16'd0, 1'b0, 1'b0);
    chk("t1_latency", meas_cyc - first, WN);
    chk("t3_peak", peak_o, 15);
    chk("t3_mean", mean_o, 7);
    chk("t3_cnt", ovf_count_o, 0);
    chk("t3_flag", ovf_flag_o, 0);
    chk("t3_hold_cycles", hold_hi_n, 0);

    // Full-scale negative
    drive(16'd0, 1'b0, 1'b1);
    thresh_i = 15'd30000;
    repeat (WN) drive(16'h8000, 1'b1, 1'b0);
    repeat (3) drive(16'd0, 1'b0, 1'b0);
    chk("t2_peak", peak_o, 32767);
    chk("t2_mean", mean_o, 32767);
    chk("t2_cnt", ovf_count_o, 16);
    chk("t2_flag", ovf_flag_o, 1);

    // Hold timing with a retriggering overload
    drive(16'd0, 1'b0, 1'b1);
    drive(16'd0, 1'b0, 1'b0);
    thresh_i = 15'd1000;
    hold_hi_n = 0;
    drive(16'd2000, 1'b1, 1'b0);
    repeat (4) drive(16'd0, 1'b1, 1'b0);
    drive(16'd2000, 1'b1, 1'b0);
    repeat (12) drive(16'd0, 1'b1, 1'b0);
    repeat (3) drive(16'd0, 1'b0, 1'b0);
    chk("t4_hold_cycles", hold_hi_n, 13);
    chk("t4_peak", peak_o, 2000);
    chk("t4_mean", mean_o, 250);
    chk("t4_cnt", ovf_count_o, 2);

    // Clear coinciding with the window-closing cycle and an overload
    drive(16'd0, 1'b0, 1'b1);
    thresh_i = 15'd1000;
    repeat (WN - 1) drive(16'd100, 1'b1, 1'b0);
    drive(16'd5000, 1'b1, 1'b0);
    meas_before = meas_n;
    drive(16'd0, 1'b0, 1'b1);
    repeat (2) drive(16'd0, 1'b0, 1'b0);
    chk("t5_no_meas", meas_n - meas_before, 0);
    chk("t5_peak_kept", peak_o, 2000);
    chk("t5_mean_kept", mean_o, 250);
    chk("t5_cnt_kept", ovf_count_o, 2);
    chk("t5_flag", ovf_flag_o, 1);
    chk("t5_hold", ovf_hold_o, 1);
    repeat (WN) drive(16'd50, 1'b1, 1'b0);
    repeat (3) drive(16'd0, 1'b0, 1'b0);
    chk("t5_next_peak", peak_o, 50);
    chk("t5_next_mean", mean_o, 50);
    chk("t5_next_cnt", ovf_count_o, 0);

    // Gated input: disabled full-scale samples must be ignored
    drive(16'd0, 1'b0, 1'b1);
    thresh_i = 15'd0;
    meas_cyc = 0;
    first = 0;
    for (int i = 0; i < WN; i++) begin
      drive(16'(i * 100), 1'b1, 1'b0);
      if (i == 0) first = last_cap;
      drive(16'd32767, 1'b0, 1'b0);
    end
    repeat (3) drive(16'd0, 1'b0, 1'b0);
    chk("t6_latency", meas_cyc - first, 2 * WN - 1);
    chk("t6_peak", peak_o, 1500);
    chk("t6_mean", mean_o, 750);
    chk("t6_cnt", ovf_count_o, 0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
